// File: rtl/operand_load_ctrl.sv
// Operand loader: synchronised, debounced pushbutton steps an A/B/SHOW FSM that latches sw into reg_a/reg_b.
// Optional registered sum output (reg_a+reg_b) is compiled in with `define OPERAND_LOAD_CTRL_SUM_EN.
module operand_load_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sw,
  input  logic        key_load,
  output logic [15:0] reg_a,
  output logic [15:0] reg_b,
  output logic        load_a,
  output logic        load_b,
  output logic [1:0]  state
`ifdef OPERAND_LOAD_CTRL_SUM_EN
  ,
  output logic [16:0] sum
`endif
);

  localparam int unsigned CW = 20;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_e;

  logic [1:0]    sync_q, sync_d;
  logic [1:0]    flush_q, flush_d;
  logic          armed_q, armed_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          press_q, press_d;
  state_e        state_q, state_d;
  logic [15:0]   reg_a_q, reg_a_d;
  logic [15:0]   reg_b_q, reg_b_d;
  logic          load_a_q, load_a_d;
  logic          load_b_q, load_b_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= '1;
      flush_q  <= '0;
      armed_q  <= 1'b0;
      deb_q    <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      flush_q  <= flush_d;
      armed_q  <= armed_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
    end
  end

  // Presses are only honoured once a released key has been seen after reset,
  // so a key held through reset cannot produce a pulse when it debounces low.
  always_comb begin
    sync_d  = {sync_q[0], key_load};
    flush_d = {flush_q[0], 1'b1};
    armed_d = armed_q | (flush_q[1] & sync_q[1] & deb_q);
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != deb_q) begin
      if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
        deb_d   = sync_q[1];
        press_d = deb_q & armed_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (press_q) state_d = LOAD_B;
      LOAD_B:  if (press_q) state_d = SHOW;
      SHOW:    if (press_q) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  always_comb begin
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    load_a_d = 1'b0;
    load_b_d = 1'b0;
    if (press_q && (state_q == LOAD_A)) begin
      reg_a_d  = sw;
      load_a_d = 1'b1;
    end
    if (press_q && (state_q == LOAD_B)) begin
      reg_b_d  = sw;
      load_b_d = 1'b1;
    end
  end

  assign reg_a  = reg_a_q;
  assign reg_b  = reg_b_q;
  assign load_a = load_a_q;
  assign load_b = load_b_q;
  assign state  = state_q;

`ifdef OPERAND_LOAD_CTRL_SUM_EN
  logic [16:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_b_q) sum_d = {1'b0, reg_a_q} + {1'b0, reg_b_q};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;
`else
`endif

endmodule

// File: tb/tb_operand_load_ctrl.sv
// Self-checking bench for operand_load_ctrl with DEBOUNCE_CYCLES=4; random presses/glitches vs an event-level model.
// Define OPERAND_LOAD_CTRL_SUM_EN on both files to also check the sum output.
module tb_operand_load_ctrl;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sw;
  logic        key_load;
  logic [15:0] reg_a, reg_b;
  logic        load_a, load_b;
  logic [1:0]  state;
`ifdef OPERAND_LOAD_CTRL_SUM_EN
  logic [16:0] sum;
  logic [16:0] msum;
  logic        eb_prev;
`endif

  operand_load_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (sw),
    .key_load (key_load),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .load_a   (load_a),
    .load_b   (load_b),
    .state    (state)
`ifdef OPERAND_LOAD_CTRL_SUM_EN
    ,
    .sum      (sum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pend_cyc = -1;
  int last_fall = 0;
  int last_load_a_cyc = -1;
  int na = 0;
  int nb = 0;
  int mstate = 0;
  logic [15:0] ma = '0;
  logic [15:0] mb = '0;
  logic [15:0] psw = '0;

  // One clock: advance the model by the event rules, then compare every output.
  task automatic tick();
    logic rs;
    logic ea, eb;
    rs = reset_n;
    @(posedge clk);
    #1;
    cyc++;
    ea = 1'b0;
    eb = 1'b0;
    if (!rs) begin
      mstate   = 0;
      ma       = '0;
      mb       = '0;
      pend_cyc = -1;
`ifdef OPERAND_LOAD_CTRL_SUM_EN
      msum    = '0;
`endif
    end else begin
`ifdef OPERAND_LOAD_CTRL_SUM_EN
      if (eb_prev) msum = {1'b0, ma} + {1'b0, mb};
`endif
      if (pend_cyc == cyc) begin
        if (mstate == 0) begin ma = psw; ea = 1'b1; end
        if (mstate == 1) begin mb = psw; eb = 1'b1; end
        mstate   = (mstate + 1) % 3;
        pend_cyc = -1;
      end
    end
`ifdef OPERAND_LOAD_CTRL_SUM_EN
    eb_prev = eb;
    checks++;
    if (sum !== msum) begin
      failures++;
      $display("FAIL sum cyc=%0d: got %h expected %h", cyc, sum, msum);
    end
`endif
    checks++;
    if (load_a !== ea) begin
      failures++;
      $display("FAIL load_a cyc=%0d: got %b expected %b", cyc, load_a, ea);
    end
    checks++;
    if (load_b !== eb) begin
      failures++;
      $display("FAIL load_b cyc=%0d: got %b expected %b", cyc, load_b, eb);
    end
    checks++;
    if (reg_a !== ma) begin
      failures++;
      $display("FAIL reg_a cyc=%0d: got %h expected %h", cyc, reg_a, ma);
    end
    checks++;
    if (reg_b !== mb) begin
      failures++;
      $display("FAIL reg_b cyc=%0d: got %h expected %h", cyc, reg_b, mb);
    end
    checks++;
    if (state !== 2'(mstate)) begin
      failures++;
      $display("FAIL state cyc=%0d: got %b expected %0d", cyc, state, mstate);
    end
    if (load_a === 1'b1) begin
      na++;
      last_load_a_cyc = cyc;
    end
    if (load_b === 1'b1) nb++;
  endtask

  // Clean press: key low for low_len cycles (>= D), then released for high_len cycles.
  task automatic press(input logic [15:0] v, input int low_len, input int high_len);
    sw        = v;
    psw       = v;
    key_load  = 1'b0;
    last_fall = cyc;
    pend_cyc  = cyc + int'(D) + 3;
    repeat (low_len) tick();
    key_load = 1'b1;
    repeat (high_len) tick();
  endtask

  task automatic glitch(input int g);
    sw       = 16'($urandom);
    key_load = 1'b0;
    repeat (g) tick();
    key_load = 1'b1;
    repeat (D + 3) tick();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    key_load = 1'b1;
    sw       = 16'h0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (D + 3) tick();
  endtask

  task automatic test_load_a();
    press(16'h1234, D, D + 6);
    checks++;
    if (last_load_a_cyc - last_fall !== int'(D) + 3) begin
      failures++;
      $display("FAIL latency: got %0d expected %0d", last_load_a_cyc - last_fall, D + 3);
    end
    checks++;
    if (reg_a !== 16'h1234 || state !== 2'b01) begin
      failures++;
      $display("FAIL load_a_result: got reg_a=%h state=%b expected 1234/01", reg_a, state);
    end
  endtask

  task automatic test_load_b();
    int nb0;
    nb0 = nb;
    press(16'hFFFF, D + 2, D + 6);
    checks++;
    if (reg_b !== 16'hFFFF || state !== 2'b10 || nb - nb0 !== 1) begin
      failures++;
      $display("FAIL load_b_result: got reg_b=%h state=%b pulses=%0d expected ffff/10/1", reg_b, state, nb - nb0);
    end
  endtask

  task automatic test_show();
    press(16'h0BAD, D, D + 6);
    checks++;
    if (reg_a !== 16'h1234 || reg_b !== 16'hFFFF || state !== 2'b00) begin
      failures++;
      $display("FAIL show_hold: got %h/%h/%b expected 1234/ffff/00", reg_a, reg_b, state);
    end
  endtask

  task automatic test_glitch();
    int na0;
    na0 = na;
    glitch(3);
    checks++;
    if (na != na0 || reg_a !== 16'h1234 || state !== 2'b00) begin
      failures++;
      $display("FAIL glitch: got pulses=%0d reg_a=%h state=%b expected 0/1234/00", na - na0, reg_a, state);
    end
  endtask

  task automatic test_sum();
    press(16'h0001, D, D + 6);
    press(16'hFFFF, D, D + 6);
`ifdef OPERAND_LOAD_CTRL_SUM_EN
    checks++;
    if (sum !== 17'h10000) begin
      failures++;
      $display("FAIL sum_carry: got %h expected 10000", sum);
    end
`endif
    press(16'h7777, D, D + 6);
  endtask

  task automatic test_hold();
    int na0;
    na0 = na;
    press(16'hC0DE, 100, D + 6);
    checks++;
    if (na - na0 !== 1 || state !== 2'b01) begin
      failures++;
      $display("FAIL hold: got pulses=%0d state=%b expected 1/01", na - na0, state);
    end
    press(16'hBEEF, D, D + 6);
    checks++;
    if (state !== 2'b10 || reg_b !== 16'hBEEF) begin
      failures++;
      $display("FAIL hold_next: got state=%b reg_b=%h expected 10/beef", state, reg_b);
    end
    press(16'h1111, D, D + 6);
    press(16'h2222, D, D + 6);
  endtask

  task automatic test_reset_held();
    int na0, nb0;
    sw       = 16'h3333;
    psw      = 16'h3333;
    key_load = 1'b0;
    pend_cyc = cyc + int'(D) + 3;
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    na0 = na;
    nb0 = nb;
    repeat (30) tick();
    checks++;
    if (na != na0 || nb != nb0 || state !== 2'b00 || reg_a !== 16'h0 || reg_b !== 16'h0) begin
      failures++;
      $display("FAIL reset_held: got pulses=%0d state=%b regs=%h/%h expected 0/00/0/0",
               na - na0 + nb - nb0, state, reg_a, reg_b);
    end
    key_load = 1'b1;
    repeat (D + 4) tick();
    press(16'h4444, D, D + 6);
    checks++;
    if (reg_a !== 16'h4444 || state !== 2'b01) begin
      failures++;
      $display("FAIL repress: got reg_a=%h state=%b expected 4444/01", reg_a, state);
    end
  endtask

  task automatic test_three();
    for (int i = 0; i < 3 && mstate != 0; i++) press(16'($urandom), D, D + 6);
    press(16'hAAAA, D, D + 6);
    press(16'h5555, D, D + 6);
    press(16'h9999, D, D + 6);
    checks++;
    if (reg_a !== 16'hAAAA || reg_b !== 16'h5555 || state !== 2'b00) begin
      failures++;
      $display("FAIL three: got %h/%h/%b expected aaaa/5555/00", reg_a, reg_b, state);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, D - 1)));
      else press(16'($urandom), int'($urandom_range(D, D + 12)), int'($urandom_range(D + 2, D + 8)));
    end
  endtask

  initial begin
`ifdef OPERAND_LOAD_CTRL_SUM_EN
    msum    = '0;
    eb_prev = 1'b0;
`endif
    reset_n  = 1'b0;
    key_load = 1'b1;
    sw       = '0;
    test_reset();
    test_load_a();
    test_load_b();
    test_show();
    test_glitch();
    test_sum();
    test_hold();
    test_reset_held();
    test_three();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
